// File: rtl/bits_pkg.sv
// bits_pkg: shared FSM state, default sizes and MAX_REQ derivation for the bit-stream unpacker.
package bits_pkg;
    typedef enum logic {IDLE, WAIT} state_t;
    localparam int WORD_W_DEF = 32;
    localparam int DEPTH_DEF = 32;
    localparam int LEN_W_DEF = 4;
    function automatic int max_req(input int len_w);
        return (1 << len_w) - 1;
    endfunction
endpackage

// File: rtl/bits_word_fifo.sv
// bits_word_fifo: word FIFO with registered count, sticky overflow on dropped pushes and async head read.
module bits_word_fifo
    import bits_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int AW = $clog2(DEPTH),
    localparam int CNT_W = AW + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [WORD_W-1:0] datain,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic [WORD_W-1:0] head
);
    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic push_ok, pop_ok;
    assign full = count == CNT_W'(DEPTH);
    assign empty = count == '0;
    assign push_ok = push && !full;
    assign pop_ok = pop && !empty;
    assign head = mem[rd_ptr];
    always_ff @(posedge clock)
        if (push_ok) mem[wr_ptr] <= datain;
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            if (push && full) overflow <= 1'b1;
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
endmodule

// File: rtl/bits_stream_unpacker.sv
// bits_stream_unpacker: word FIFO feeding a two-word bit accumulator that serves 0..MAX_REQ-bit fields on request.
// Define BITS_LSB_FIRST_EN to consume each word LSB first; MSB first otherwise.
module bits_stream_unpacker
    import bits_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int LEN_W = LEN_W_DEF,
    localparam int MAX_REQ = max_req(LEN_W)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               pushin,
    input  logic [WORD_W-1:0]  datain,
    output logic               full,
    output logic               overflow,
    input  logic               reqin,
    input  logic [LEN_W-1:0]   reqlen,
    output logic               busy,
    output logic               pushout,
    output logic [LEN_W-1:0]   lenout,
    output logic [MAX_REQ-1:0] dataout
);
    localparam int ACC_W = 2 * WORD_W;
    localparam int CW = $clog2(ACC_W + 1);
    state_t state, state_n;
    logic [LEN_W-1:0] len_q, len_n, len;
    logic serve, pop, empty;
    logic [WORD_W-1:0] head;
    logic [ACC_W-1:0] acc, acc_n, shifted, incoming;
    logic [CW-1:0] acc_cnt, cnt_n, used, post;
    logic [MAX_REQ-1:0] field;
    bits_word_fifo #(.WORD_W(WORD_W), .DEPTH(DEPTH)) u_fifo (
        .clock(clock), .reset(reset), .push(pushin), .datain(datain), .pop(pop),
        .full(full), .empty(empty), .overflow(overflow), .head(head)
    );
    assign busy = state == WAIT;
    always_comb begin
        state_n = state;
        len_n = len_q;
        serve = 1'b0;
        len = state == WAIT ? len_q : reqlen;
        if (state == IDLE && reqin) begin
            serve = acc_cnt >= CW'(reqlen);
            state_n = serve ? IDLE : WAIT;
            len_n = reqlen;
        end else if (state == WAIT && acc_cnt >= CW'(len_q)) begin
            serve = 1'b1;
            state_n = IDLE;
        end
    end
    // Valid bits sit at the consuming end of acc; a popped word lands right behind the post-consume remainder.
    always_comb begin
        used = serve ? CW'(len) : '0;
        post = acc_cnt - used;
        pop = !empty && post <= CW'(WORD_W);
`ifdef BITS_LSB_FIRST_EN
        field = acc[MAX_REQ-1:0] & ~({MAX_REQ{1'b1}} << len);
        shifted = acc >> used;
        incoming = {{WORD_W{1'b0}}, head} << post;
`else
        field = MAX_REQ'(acc >> (CW'(ACC_W) - CW'(len)));
        shifted = acc << used;
        incoming = {head, {WORD_W{1'b0}}} >> post;
`endif
        acc_n = pop ? shifted | incoming : shifted;
        cnt_n = pop ? post + CW'(WORD_W) : post;
    end
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            state <= IDLE;
            len_q <= '0;
        end else begin
            state <= state_n;
            len_q <= len_n;
        end
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            acc <= '0;
            acc_cnt <= '0;
            pushout <= 1'b0;
            lenout <= '0;
            dataout <= '0;
        end else begin
            acc <= acc_n;
            acc_cnt <= cnt_n;
            pushout <= serve;
            if (serve) begin
                lenout <= len;
                dataout <= field;
            end
        end
endmodule
